// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : button_event_gen
// Brief    : Turns a debounced button level into single-cycle press, release,
//            long-press and optional auto-repeat events.
// Options  : `define BUTTON_AUTO_REPEAT_EN enables repeat_pulse in LONG.
//            When undefined, repeat_pulse is 0 and REPEAT_CYCLES is unused.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_gen #(
  parameter int CNT_W         = 24,
  parameter int LONG_CYCLES   = 10_000_000,
  parameter int REPEAT_CYCLES = 2_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       enable,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_long_term = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  // Reject parameter sets the hold counter cannot represent.
  if (LONG_CYCLES < 2 || LONG_CYCLES >= (2 ** CNT_W)) begin : g_bad_long
    $error("button_event_gen: LONG_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES >= (2 ** CNT_W)) begin : g_bad_repeat
    $error("button_event_gen: REPEAT_CYCLES out of range");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_q;
  logic             w_rise;
  logic             w_fall;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_repeat_term = CNT_W'(REPEAT_CYCLES - 1);
  logic r_repeat;
`endif

  // Edge detect against the previous level; btn_q resets to 1 so a button
  // held through reset does not look like a fresh press.
  assign w_rise = btn_in & ~r_btn_q;
  assign w_fall = ~btn_in & r_btn_q;

  // Event FSM: state, hold counter and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_btn_q       <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      r_repeat      <= 1'b0;
`endif
    end else begin
      r_btn_q       <= btn_in;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      r_repeat      <= 1'b0;
`endif
      if (!enable) begin
        // Disabled: silently drop to IDLE, no release event.
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (w_rise) begin
              r_state     <= ST_PRESSED;
              press_pulse <= 1'b1;
              held        <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if (w_fall) begin
              r_state       <= ST_IDLE;
              r_cnt         <= '0;
              release_pulse <= 1'b1;
            end else if (r_cnt == c_long_term) begin
              r_state    <= ST_LONG;
              r_cnt      <= '0;
              long_pulse <= 1'b1;
              held       <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
              held  <= 1'b1;
            end
          end
          ST_LONG: begin
            if (w_fall) begin
              r_state       <= ST_IDLE;
              r_cnt         <= '0;
              release_pulse <= 1'b1;
            end else begin
              held <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
              if (r_cnt == c_repeat_term) begin
                r_cnt    <= '0;
                r_repeat <= 1'b1;
              end else begin
                r_cnt <= r_cnt + c_cnt_one;
              end
`else
              r_cnt <= '0;
`endif
            end
          end
          default: begin
            // Illegal encoding recovers to IDLE.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_gen
// Brief    : Directed self-checking bench for button_event_gen with
//            LONG_CYCLES=8, REPEAT_CYCLES=4. Honours BUTTON_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_gen;

  logic       clock;
  logic       reset;
  logic       btn_in;
  logic       enable;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [1:0] state_o;
  logic [6:0] obs;

  int errors = 0;
  int checks = 0;

  button_event_gen #(
    .CNT_W         (24),
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_in        (btn_in),
    .enable        (enable),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .state_o       (state_o)
  );

  // Observed vector: {press, release, long, repeat, held, state[1:0]}
  assign obs = {press_pulse, release_pulse, long_pulse, repeat_pulse, held, state_o};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Return to a quiet IDLE with btn_q=0.
  task automatic settle();
    btn_in = 1'b0;
    enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    reset  = 1'b0;
    btn_in = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 7'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL held_through_reset cyc=%0d got=%b want=%b", i, obs, 7'b0);
      end
    end
    btn_in = 1'b0;
    tick();
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_btn_low got=%b want=%b", obs, 7'b0);
    end
    btn_in = 1'b1;
    tick();
    exp = 7'b1000101;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_first_press got=%b want=%b", obs, exp);
    end
    btn_in = 1'b0;
    tick();
    exp = 7'b0100000;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_first_release got=%b want=%b", obs, exp);
    end
    settle();
  endtask

  task automatic test_short_press();
    logic [6:0] exp;
    for (int i = 0; i < 5; i++) begin
      btn_in = (i < 3);
      tick();
      case (i)
        0:       exp = 7'b1000101;
        1, 2:    exp = 7'b0000101;
        3:       exp = 7'b0100000;
        default: exp = 7'b0000000;
      endcase
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL short_press cyc=%0d got=%b want=%b", i, obs, exp);
      end
    end
    settle();
  endtask

  task automatic test_long_hold();
    logic [6:0] exp;
    logic       p, r, l, rp, h;
    logic [1:0] st;
    for (int i = 0; i < 32; i++) begin
      btn_in = (i < 30);
      tick();
      p  = (i == 0);
      l  = (i == 8);
      r  = (i == 30);
`ifdef BUTTON_AUTO_REPEAT_EN
      rp = (i > 8) && (i < 30) && (((i - 8) % 4) == 0);
`else
      rp = 1'b0;
`endif
      h  = (i < 30);
      st = (i < 8) ? 2'd1 : (i < 30) ? 2'd2 : 2'd0;
      exp = {p, r, l, rp, h, st};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_hold cyc=%0d got=%b want=%b", i, obs, exp);
      end
    end
    settle();
  endtask

  task automatic test_release_at_terminal();
    logic [6:0] exp;
    for (int i = 0; i < 10; i++) begin
      btn_in = (i < 8);
      tick();
      if (i == 0)     exp = 7'b1000101;
      else if (i < 8) exp = 7'b0000101;
      else if (i == 8) exp = 7'b0100000;
      else            exp = 7'b0000000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL release_at_terminal cyc=%0d got=%b want=%b", i, obs, exp);
      end
    end
    settle();
  endtask

  task automatic test_fall_beats_repeat();
    logic [6:0] exp;
    for (int i = 0; i < 14; i++) begin
      btn_in = (i < 12);
      tick();
      if (i == 0)       exp = 7'b1000101;
      else if (i < 8)   exp = 7'b0000101;
      else if (i == 8)  exp = 7'b0010110;
      else if (i < 12)  exp = 7'b0000110;
      else if (i == 12) exp = 7'b0100000;
      else              exp = 7'b0000000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL fall_beats_repeat cyc=%0d got=%b want=%b", i, obs, exp);
      end
    end
    settle();
  endtask

  task automatic test_enable_drop();
    logic [6:0] exp;
    logic       p, r, l, h;
    logic [1:0] st;
    for (int i = 0; i < 20; i++) begin
      btn_in = (i < 15) || (i == 16) || (i == 17);
      enable = !((i == 10) || (i == 11));
      tick();
      p  = (i == 0) || (i == 16);
      l  = (i == 8);
      r  = (i == 18);
      if (i < 8)                    st = 2'd1;
      else if (i < 10)              st = 2'd2;
      else if (i == 16 || i == 17)  st = 2'd1;
      else                          st = 2'd0;
      h  = (st != 2'd0);
      exp = {p, r, l, 1'b0, h, st};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL enable_drop cyc=%0d got=%b want=%b", i, obs, exp);
      end
    end
    settle();
  endtask

  task automatic test_async_reset();
    logic [6:0] exp;
    for (int i = 0; i < 9; i++) begin
      btn_in = 1'b1;
      tick();
    end
    exp = 7'b0010110;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_pre_long got=%b want=%b", obs, exp);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_clear got=%b want=%b", obs, 7'b0);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL async_reset_no_press cyc=%0d got=%b want=%b", i, obs, 7'b0);
      end
    end
    settle();
  endtask

  initial begin
    reset  = 1'b0;
    btn_in = 1'b1;
    enable = 1'b1;
    test_reset();
    test_short_press();
    test_long_hold();
    test_release_at_terminal();
    test_fall_beats_repeat();
    test_enable_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
